// File: rtl/gpu_sched_pkg.sv
// Shared configuration and types for the fetch warp scheduler.
package gpu_sched_pkg;
    localparam int NUM_WARPS  = 8;
    localparam int IBUF_DEPTH = 2;
    localparam int FLUSH_HOLD = 2;

    localparam int CREDIT_W = $clog2(IBUF_DEPTH + 1);
    localparam int HOLD_W   = $clog2(FLUSH_HOLD + 1);
    localparam int IDX_W    = $clog2(NUM_WARPS);

    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(IBUF_DEPTH);
    localparam logic [HOLD_W-1:0]   HOLD_INIT   = HOLD_W'(FLUSH_HOLD);

    typedef logic [NUM_WARPS-1:0] warp_mask_t;
    typedef logic [IDX_W-1:0]     warp_idx_t;

    // Circular successor; safe for non-power-of-two warp counts.
    function automatic warp_idx_t wrap_inc(input warp_idx_t i);
        return (i == warp_idx_t'(NUM_WARPS - 1)) ? '0 : warp_idx_t'(i + 1'b1);
    endfunction
endpackage

// File: rtl/rr_pick.sv
// Circular find-first: first set bit of mask scanning upward from start.
module rr_pick
    import gpu_sched_pkg::*;
(
    input  warp_mask_t mask,
    input  warp_idx_t  start,
    output logic       vld,
    output warp_idx_t  idx,
    output warp_mask_t onehot
);
    always_comb begin
        int j;
        vld    = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            j = (int'(start) + k) % NUM_WARPS;
            if (!vld && mask[j]) begin
                vld = 1'b1;
                idx = warp_idx_t'(j);
            end
        end
        if (vld) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/fetch_warp_scheduler.sv
// Dual-issue round-robin fetch scheduler with per-warp IBuffer credits and
// post-flush hold-off; both grants are registered one cycle after selection.
module fetch_warp_scheduler
    import gpu_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       Sched_En,
    input  warp_mask_t PC_Valid,
    input  warp_mask_t Flush_Sched,
    input  warp_mask_t Dequeue_IB_Sched,
    output warp_mask_t GRT_raw_1_RR_IF,
    output warp_mask_t GRT_raw_2_RR_IF,
    output warp_mask_t Credit_Empty
);
    logic [CREDIT_W-1:0] credit      [NUM_WARPS];
    logic [CREDIT_W-1:0] credit_next [NUM_WARPS];
    logic [HOLD_W-1:0]   hold        [NUM_WARPS];
    warp_idx_t  ptr, g1, g2, start2;
    warp_mask_t eligible, oh1, oh2, mask2, granted;
    logic       v1, v2;

    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++)
            eligible[i] = Sched_En & PC_Valid[i] & ~Flush_Sched[i] &
                          (hold[i] == '0) & (credit[i] != '0);
    end

    rr_pick u_pick1 (.mask(eligible), .start(ptr),    .vld(v1), .idx(g1), .onehot(oh1));

    // Second port scans on from just past the first winner, which it may not take.
    assign start2 = wrap_inc(g1);
    assign mask2  = eligible & ~oh1;

    rr_pick u_pick2 (.mask(mask2),    .start(start2), .vld(v2), .idx(g2), .onehot(oh2));

    assign granted = oh1 | oh2;

    // Flush reloads the credit and wins over a same-cycle grant or dequeue.
    always_comb begin
        for (int i = 0; i < NUM_WARPS; i++) begin
            credit_next[i] = credit[i];
            if (Flush_Sched[i])
                credit_next[i] = CREDIT_FULL;
            else if (granted[i] && !Dequeue_IB_Sched[i])
                credit_next[i] = credit[i] - 1'b1;
            else if (!granted[i] && Dequeue_IB_Sched[i] && credit[i] != CREDIT_FULL)
                credit_next[i] = credit[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            GRT_raw_1_RR_IF <= '0;
            GRT_raw_2_RR_IF <= '0;
            Credit_Empty    <= '0;
            ptr             <= '0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                credit[i] <= CREDIT_FULL;
                hold[i]   <= '0;
            end
        end else begin
            GRT_raw_1_RR_IF <= oh1;
            GRT_raw_2_RR_IF <= oh2;
            if (v2)      ptr <= wrap_inc(g2);
            else if (v1) ptr <= wrap_inc(g1);
            for (int i = 0; i < NUM_WARPS; i++) begin
                credit[i]       <= credit_next[i];
                Credit_Empty[i] <= (credit_next[i] == '0);
                if (Flush_Sched[i])     hold[i] <= HOLD_INIT;
                else if (hold[i] != '0) hold[i] <= hold[i] - 1'b1;
            end
        end
    end

    // An unmatched dequeue on a full warp means the IBuffer popped an entry never granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WARPS; i++)
                assert (!(Dequeue_IB_Sched[i] && !Flush_Sched[i] && !granted[i] &&
                          credit[i] == CREDIT_FULL));
        end
    end
endmodule

// File: tb/tb_fetch_warp_scheduler.sv
// Directed bench with a cycle-level reference model feeding an expected-grant scoreboard.
module tb_fetch_warp_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Sched_En = 1'b0;
    logic [7:0] PC_Valid = '0, Flush_Sched = '0, Dequeue_IB_Sched = '0;
    logic [7:0] GRT_raw_1_RR_IF, GRT_raw_2_RR_IF, Credit_Empty;

    int checks = 0;
    int errors = 0;

    int m_credit [8];
    int m_hold   [8];
    int m_ptr;
    logic [7:0]  last_grant;
    logic [23:0] sb_q [$];

    always #5 clk = ~clk;

    fetch_warp_scheduler dut (
        .clk(clk), .rst(rst), .Sched_En(Sched_En), .PC_Valid(PC_Valid),
        .Flush_Sched(Flush_Sched), .Dequeue_IB_Sched(Dequeue_IB_Sched),
        .GRT_raw_1_RR_IF(GRT_raw_1_RR_IF), .GRT_raw_2_RR_IF(GRT_raw_2_RR_IF),
        .Credit_Empty(Credit_Empty)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model one clock: build expected registered outputs, push them, advance the edge, compare.
    task automatic step(input logic r, input logic en, input logic [7:0] pcv,
                        input logic [7:0] fl, input logic [7:0] dq);
        logic [7:0] elig, e1, e2, ce;
        logic [23:0] got;
        int a, b, w;
        rst = r; Sched_En = en; PC_Valid = pcv; Flush_Sched = fl; Dequeue_IB_Sched = dq;
        e1 = '0; e2 = '0; ce = '0;
        if (r) begin
            m_ptr = 0;
            for (int i = 0; i < 8; i++) begin m_credit[i] = 2; m_hold[i] = 0; end
        end else begin
            for (int i = 0; i < 8; i++)
                elig[i] = en && pcv[i] && !fl[i] && m_hold[i] == 0 && m_credit[i] > 0;
            a = -1; b = -1;
            for (int k = 0; k < 8; k++) begin
                w = (m_ptr + k) % 8;
                if (a < 0 && elig[w]) a = w;
            end
            if (a >= 0) begin
                for (int k = 1; k < 8; k++) begin
                    w = (a + k) % 8;
                    if (b < 0 && elig[w]) b = w;
                end
            end
            if (a >= 0) e1[a] = 1'b1;
            if (b >= 0) e2[b] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (fl[i]) begin
                    m_credit[i] = 2; m_hold[i] = 2;
                end else begin
                    if (m_hold[i] > 0) m_hold[i]--;
                    if ((i == a || i == b) && !dq[i]) m_credit[i]--;
                    else if (!(i == a || i == b) && dq[i] && m_credit[i] < 2) m_credit[i]++;
                end
                ce[i] = (m_credit[i] == 0);
            end
            if (b >= 0) m_ptr = (b + 1) % 8;
            else if (a >= 0) m_ptr = (a + 1) % 8;
        end
        last_grant = e1 | e2;
        sb_q.push_back({e1, e2, ce});
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("grt1", GRT_raw_1_RR_IF, got[23:16]);
        chk("grt2", GRT_raw_2_RR_IF, got[15:8]);
        chk("credit_empty", Credit_Empty, got[7:0]);
    endtask

    initial begin
        logic [7:0] p1, p2;
        last_grant = '0;

        // Reset state
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("rst_grt1", GRT_raw_1_RR_IF, 8'h00);
        chk("rst_grt2", GRT_raw_2_RR_IF, 8'h00);
        chk("rst_ce", Credit_Empty, 8'h00);

        // 1: all warps valid, no dequeues -> pairs rotate until credits drain
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00);
            p1 = 8'h01 << (2 * (i % 4));
            p2 = 8'h02 << (2 * (i % 4));
            chk("t1_grt1", GRT_raw_1_RR_IF, p1);
            chk("t1_grt2", GRT_raw_2_RR_IF, p2);
        end
        step(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00);
        chk("t1_idle1", GRT_raw_1_RR_IF, 8'h00);
        chk("t1_idle2", GRT_raw_2_RR_IF, 8'h00);
        chk("t1_ce", Credit_Empty, 8'hFF);

        // 2: one dequeue of warp 3 returns exactly one grant to it
        step(1'b0, 1'b1, 8'hFF, 8'h00, 8'h08);
        chk("t2_ce", Credit_Empty, 8'hF7);
        step(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00);
        chk("t2_grt1", GRT_raw_1_RR_IF, 8'h08);
        chk("t2_grt2", GRT_raw_2_RR_IF, 8'h00);
        step(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00);
        chk("t2_idle", GRT_raw_1_RR_IF, 8'h00);

        // 3: single warp with matching dequeue each cycle stays at credit 1
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'h10, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h10, 8'h00, 8'h10);
            chk("t3_grt1", GRT_raw_1_RR_IF, 8'h10);
            chk("t3_grt2", GRT_raw_2_RR_IF, 8'h00);
        end
        step(1'b0, 1'b1, 8'h00, 8'h00, 8'h10);
        step(1'b0, 1'b1, 8'h10, 8'h00, 8'h00);
        chk("t3_refill", GRT_raw_1_RR_IF, 8'h10);

        // 4: stream with dequeues returning last cycle's grants; flush warp 2 for one cycle
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00);
        chk("t4_c0", GRT_raw_1_RR_IF | GRT_raw_2_RR_IF, 8'h03);
        step(1'b0, 1'b1, 8'hFF, 8'h04, last_grant);
        chk("t4_flush_e1", (GRT_raw_1_RR_IF | GRT_raw_2_RR_IF) & 8'h04, 8'h00);
        step(1'b0, 1'b1, 8'hFF, 8'h00, last_grant);
        chk("t4_hold_e2", (GRT_raw_1_RR_IF | GRT_raw_2_RR_IF) & 8'h04, 8'h00);
        step(1'b0, 1'b1, 8'hFF, 8'h00, last_grant);
        chk("t4_hold_e3", (GRT_raw_1_RR_IF | GRT_raw_2_RR_IF) & 8'h04, 8'h00);
        step(1'b0, 1'b1, 8'hFF, 8'h00, last_grant);
        chk("t4_regrant1", GRT_raw_1_RR_IF, 8'h02);
        chk("t4_regrant2", GRT_raw_2_RR_IF, 8'h04);

        // 5: flush + dequeue on warp 3 exactly when it would win port 0
        step(1'b0, 1'b1, 8'hFF, 8'h08, last_grant | 8'h08);
        chk("t5_grt1", GRT_raw_1_RR_IF, 8'h10);
        chk("t5_grt2", GRT_raw_2_RR_IF, 8'h20);

        // 6: three disabled cycles freeze rotation; it resumes at warp 6
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
            chk("t6_off1", GRT_raw_1_RR_IF, 8'h00);
            chk("t6_off2", GRT_raw_2_RR_IF, 8'h00);
        end
        step(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00);
        chk("t6_resume1", GRT_raw_1_RR_IF, 8'h40);
        chk("t6_resume2", GRT_raw_2_RR_IF, 8'h80);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 8'hFF, 8'h00, last_grant);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
